// File: rtl/button_event_ctrl_if.sv
// Avalon-MM slave bundle for the button event controller.
// Handshake: a write is accepted on the rising edge when chipselect=1 and write_n=0;
// readdata always holds the word at the previous cycle's address (fixed 1-cycle latency, no waitrequest).
interface button_event_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/button_event_ctrl.sv
// Push-button controller: synchronize, debounce, press/hold/auto-repeat per button,
// capture events in a W1C register and raise a maskable interrupt on the Avalon-MM bus.
module button_event_ctrl #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_BTN-1:0]       btn_in,
  button_event_ctrl_if.slave     bus,
  output logic [2*N_BTN-1:0]     dbg_state
);

  localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_T  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int CW     = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

  localparam logic [1:0] ST_RELEASED     = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  logic [N_BTN-1:0]          sync1_q, sync1_d;
  logic [N_BTN-1:0]          sync2_q, sync2_d;
  logic [N_BTN-1:0][1:0]     state_q, state_d;
  logic [N_BTN-1:0][CW-1:0]  cnt_q, cnt_d;
  logic [N_BTN-1:0]          phase_q, phase_d;
  logic [N_BTN-1:0]          evt;
  logic [N_BTN-1:0]          event_q, event_d;
  logic [N_BTN-1:0]          mask_q, mask_d;
  logic                      repeat_en_q, repeat_en_d;
  logic [31:0]               readdata_q, readdata_d;
  logic [N_BTN-1:0]          debounced;
  logic [N_BTN-1:0]          wmask;
  logic                      wr_en;
  logic                      unused_wdata;

  assign sync1_d = btn_in;
  assign sync2_d = sync1_q;

  // phase_q=0 waits REPEAT_DELAY for the first repeat, phase_q=1 spaces later repeats by REPEAT_PERIOD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    evt     = '0;
    for (int i = 0; i < N_BTN; i++) begin
      case (state_q[i])
        ST_RELEASED: begin
          cnt_d[i]   = '0;
          phase_d[i] = 1'b0;
          if (sync2_q[i]) state_d[i] = ST_PRESS_WAIT;
        end
        ST_PRESS_WAIT: begin
          if (!sync2_q[i]) begin
            state_d[i] = ST_RELEASED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DEB_LAST) begin
            state_d[i] = ST_HELD;
            cnt_d[i]   = '0;
            phase_d[i] = 1'b0;
            evt[i]     = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        ST_HELD: begin
          if (!sync2_q[i]) begin
            state_d[i] = ST_RELEASE_WAIT;
            cnt_d[i]   = '0;
            phase_d[i] = 1'b0;
          end else if (!repeat_en_q) begin
            cnt_d[i]   = '0;
            phase_d[i] = 1'b0;
          end else if (cnt_q[i] == (phase_q[i] ? PER_LAST : DLY_LAST)) begin
            cnt_d[i]   = '0;
            phase_d[i] = 1'b1;
            evt[i]     = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          if (sync2_q[i]) begin
            state_d[i] = ST_HELD;
            cnt_d[i]   = '0;
            phase_d[i] = 1'b0;
          end else if (cnt_q[i] == DEB_LAST) begin
            state_d[i] = ST_RELEASED;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < N_BTN; i++) debounced[i] = state_q[i][1];
  end

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign wmask        = bus.writedata[N_BTN-1:0];
  assign unused_wdata = ^bus.writedata[31:N_BTN];

  // A new event on the same cycle as a W1C keeps the bit set.
  always_comb begin
    event_d     = event_q;
    mask_d      = mask_q;
    repeat_en_d = repeat_en_q;
    if (wr_en) begin
      case (bus.address)
        2'd1:    event_d     = event_q & ~wmask;
        2'd2:    mask_d      = wmask;
        2'd3:    repeat_en_d = bus.writedata[0];
        default: ;
      endcase
    end
    event_d = event_d | evt;
  end

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      2'd0:    readdata_d = 32'(debounced);
      2'd1:    readdata_d = 32'(event_q);
      2'd2:    readdata_d = 32'(mask_q);
      default: readdata_d = {31'b0, repeat_en_q};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      state_q     <= {N_BTN{ST_RELEASED}};
      cnt_q       <= '0;
      phase_q     <= '0;
      event_q     <= '0;
      mask_q      <= '0;
      repeat_en_q <= 1'b0;
      readdata_q  <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      event_q     <= event_d;
      mask_q      <= mask_d;
      repeat_en_q <= repeat_en_d;
      readdata_q  <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = |(event_q & mask_q);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl: bus reads push expected {irq, readdata} into a queue,
// a monitor pops and compares one cycle later.
module tb_button_event_ctrl;
  localparam int N_BTN = 2;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [N_BTN-1:0]     btn_in;
  logic [2*N_BTN-1:0]   dbg_state;

  button_event_ctrl_if bus ();

  button_event_ctrl #(
    .N_BTN(N_BTN), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .btn_in(btn_in),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [32:0] exp_q[$];
  string       lbl_q[$];
  logic        rd_req  = 1'b0;
  logic        rd_seen = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [32:0] mon_e;
  string       mon_l;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a read issued before edge P is compared at the negedge after P.
  always @(posedge clk) rd_seen <= rd_req;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: got read with empty queue, expected an entry at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        mon_l = lbl_q.pop_front();
        check({mon_l, "_data"}, bus.readdata, mon_e[31:0]);
        check({mon_l, "_irq"}, {31'b0, bus.irq}, {31'b0, mon_e[32]});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bus cycle (called at a negedge): optional write, always a read of addr a.
  // exp_d = register before this cycle's edge, exp_irq = irq after that edge.
  task automatic op(input string lbl, input logic [1:0] a, input logic do_wr,
                    input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_irq);
    bus.address    = a;
    bus.chipselect = do_wr;
    bus.write_n    = ~do_wr;
    bus.writedata  = wd;
    exp_q.push_back({exp_irq, exp_d});
    lbl_q.push_back(lbl);
    rd_req = 1'b1;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    rd_req         = 1'b0;
  endtask

  // Press btn 0 at k=0, read EVENT every cycle; ev_at[k] = EVENT after edge k, wr_at[k] = W1C 0x1 at k.
  // Assumes IRQ_MASK = 0x1.
  task automatic hold_seq(input string lbl, input logic [127:0] wr_at, input logic [127:0] ev_at,
                          input int rel_at, input int len);
    btn_in[0] = 1'b1;
    for (int k = 0; k < len; k++) begin
      if (k == rel_at) btn_in[0] = 1'b0;
      op(lbl, 2'd1, wr_at[k], 32'h1, {31'b0, ev_at[k]}, ev_at[k+1]);
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    btn_in         = '0;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    idle(3);
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_irq", {31'b0, bus.irq}, 32'h0);
    reset_n = 1'b1;
    op("rst_deb",  2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    op("rst_evt",  2'd1, 1'b0, 32'h0, 32'h0, 1'b0);
    op("rst_mask", 2'd2, 1'b0, 32'h0, 32'h0, 1'b0);
    op("rst_ctrl", 2'd3, 1'b0, 32'h0, 32'h0, 1'b0);

    // Clean press, no repeat: EVENT at edge 7 where edge 1 first samples the pin.
    op("t1_mask_wr", 2'd2, 1'b1, 32'h1, 32'h0, 1'b0);
    hold_seq("t1_press", 128'd1 << 7, 128'd1 << 7, -1, 12);
    op("t1_deb", 2'd0, 1'b0, 32'h0, 32'h1, 1'b0);
    for (int k = 0; k < 30; k++) op("t1_norep", 2'd1, 1'b0, 32'h0, 32'h0, 1'b0);
    btn_in[0] = 1'b0;
    idle(10);
    op("t1_rel", 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);

    // Bounce on btn 1: 3 high / 1 low never completes a debounce.
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        btn_in[1] = (c < 3);
        op("t2_bounce", (c % 2 == 0) ? 2'd0 : 2'd1, 1'b0, 32'h0, 32'h0, 1'b0);
      end
    end
    btn_in[1] = 1'b1;
    idle(10);
    op("t2_event",  2'd1, 1'b0, 32'h0, 32'h2, 1'b0);
    op("t2_deb",    2'd0, 1'b0, 32'h0, 32'h2, 1'b0);
    op("t2_clr",    2'd1, 1'b1, 32'h2, 32'h2, 1'b0);
    op("t2_clr_rd", 2'd1, 1'b0, 32'h0, 32'h0, 1'b0);
    btn_in[1] = 1'b0;
    idle(10);

    // Auto-repeat: press at 7, repeats at +20, +28, +36, +44, +52.
    op("t3_ctrl_wr", 2'd3, 1'b1, 32'h1, 32'h0, 1'b0);
    op("t3_ctrl_rd", 2'd3, 1'b0, 32'h0, 32'h1, 1'b0);
    hold_seq("t3_repeat",
             (128'd1 << 7) | (128'd1 << 27) | (128'd1 << 35) | (128'd1 << 43) | (128'd1 << 51) | (128'd1 << 59),
             (128'd1 << 7) | (128'd1 << 27) | (128'd1 << 35) | (128'd1 << 43) | (128'd1 << 51) | (128'd1 << 59),
             60, 70);
    idle(4);

    // W1C lands on the same edge as the first repeat (27): bit stays set until a quiet W1C at 30.
    hold_seq("t4_race",
             (128'd1 << 7) | (128'd1 << 26) | (128'd1 << 30),
             (128'd1 << 7) | (128'd1 << 27) | (128'd1 << 28) | (128'd1 << 29) | (128'd1 << 30),
             31, 40);
    idle(10);
    op("t4_quiet", 2'd1, 1'b0, 32'h0, 32'h0, 1'b0);

    // Mask gating.
    op("t5_ctrl_off", 2'd3, 1'b1, 32'h0, 32'h1, 1'b0);
    op("t5_mask_off", 2'd2, 1'b1, 32'h0, 32'h1, 1'b0);
    btn_in[0] = 1'b1;
    idle(12);
    op("t5_masked",  2'd1, 1'b0, 32'h0, 32'h1, 1'b0);
    op("t5_unmask",  2'd2, 1'b1, 32'h1, 32'h0, 1'b1);
    op("t5_mask_rd", 2'd2, 1'b0, 32'h0, 32'h1, 1'b1);

    // Reset while btn 0 is held with an event pending.
    op("t6_ctrl_on", 2'd3, 1'b1, 32'h1, 32'h0, 1'b1);
    op("t6_pre_evt", 2'd1, 1'b0, 32'h0, 32'h1, 1'b1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_readdata", bus.readdata, 32'h0);
    check("t6_rst_irq", {31'b0, bus.irq}, 32'h0);
    idle(2);
    reset_n = 1'b1;
    for (int k = 0; k < 9; k++) op("t6_repress", 2'd1, 1'b0, 32'h0, (k >= 7) ? 32'h1 : 32'h0, 1'b0);
    op("t6_deb",  2'd0, 1'b0, 32'h0, 32'h1, 1'b0);
    op("t6_mask", 2'd2, 1'b0, 32'h0, 32'h0, 1'b0);
    op("t6_ctrl", 2'd3, 1'b0, 32'h0, 32'h0, 1'b0);
    btn_in[0] = 1'b0;
    idle(3);

    check("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: got timeout at %0t expected completion", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
